fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction prefetch buffer between instruction memory and the IF/ID pipeline register. Issues sequential fetch requests to a variable-latency imem, buffers returned words with their PC+4 in a small FIFO, and presents them in order to decode. It absorbs decode stalls without re-fetching. On a taken branch or jump it flushes all buffered and in-flight instructions and restarts at the redirect target.

## Interface
Parameters:
- DEPTH, 4, FIFO entries. Power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  imem accepts request this cycle.
- imem_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response word valid; responses return in request order, ≥1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- redirect  in  1  taken branch/jump resolved in decode (pc_src_D).
- redirect_pc  in  32  redirect target (pc_br_D); bits [1:0] ignored (forced 0).
- take  in  1  decode consumes head entry (IF/ID enable).
- valid_F  out  1  head entry valid.
- inst_F  out  32  head instruction; 0 when !valid_F.
- pc_plus4_F  out  32  head PC+4; 0 when !valid_F.
- empty  out  1  no valid entries.
- full  out  1  count == DEPTH.

## Operation
- State: fetch_pc[31:0], FIFO storage (inst, pc_plus4) × DEPTH, rd_ptr/wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH), outstanding (0..DEPTH), drop (0..DEPTH), FSM {FETCH, DRAIN}.
- Issue: imem_req_valid = (state==FETCH) & !redirect & (count + outstanding < DEPTH). imem_addr = fetch_pc. On accept: fetch_pc += 4 (mod 2^32 wrap), outstanding++. A PC is tagged on request and pushed as its pc_plus4 on response (per-slot pc_plus4 written at issue, keyed by wr_ptr+outstanding).
- Response in FETCH with drop==0: push entry; outstanding--.
- Response with drop>0: discard word, drop--, outstanding--.
- take with valid_F: pop head. take with !valid_F: ignored.
- Push and pop in the same cycle: count unchanged. Full plus push cannot occur by construction; a bench assertion checks it.
- redirect (any state): clear FIFO (count=0, pointers=0), drop = outstanding minus any response retired this cycle, fetch_pc = {redirect_pc[31:2],2'b00}. The response arriving on the redirect cycle is discarded. Next state = DRAIN if new drop>0, else FETCH. take on the redirect cycle is ignored.
- FSM: FETCH → DRAIN on redirect with in-flight requests. DRAIN → FETCH when drop reaches 0. No requests are issued in DRAIN. A further redirect in DRAIN updates fetch_pc and stays in DRAIN.
- Reset: fetch_pc=RESET_PC, count=outstanding=drop=0, state=FETCH. All outputs 0 except empty=1. Reset mid-transaction abandons in-flight requests. Responses to them that arrive after reset deasserts are ignored: a response with outstanding==0 is dropped.

## Timing
- Registered FIFO output. With bypass disabled, a response accepted in cycle N is visible as valid_F in cycle N+1.
- Best-case fetch-to-decode with 1-cycle imem: request N, response N+1, valid_F N+2.
- First request is issued in the first cycle after reset deasserts.
- After redirect in cycle N: the earliest new request is cycle N+1 if nothing is in flight; otherwise it is the cycle after the last dropped response.
- Sustained throughput: 1 instr/cycle when DEPTH ≥ imem latency + 1.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count==0 and a non-dropped response arrives, inst_F/pc_plus4_F/valid_F present it combinationally in the same cycle. If take is also high, the entry is not written. This saves one cycle of fetch latency.
- Undefined: all entries pass through FIFO storage; outputs depend only on registers.

## Test plan
- Reset, 1-cycle imem returning addr as data, take=1 constantly → requests 0,4,8,…; valid_F from cycle 2; inst_F sequence 0,4,8 with pc_plus4_F 4,8,12; one instruction per cycle.
- take=0 for 10 cycles → exactly DEPTH=4 entries buffered, full=1, imem_req_valid=0. Resume take → inst_F 0,4,8,12,16 with no gap or duplicate.
- 3-cycle imem latency, 3 requests in flight, redirect=1 with redirect_pc=32'h100 → state DRAIN, 3 responses discarded, next imem_addr=32'h100, first valid inst_F=word@0x100, pc_plus4_F=32'h104.
- Redirect in cycle with simultaneous response and take → response dropped, no pop counted, count=0, empty=1 next cycle.
- Reset asserted with 2 outstanding → all outputs 0, empty=1. Late stale responses are ignored. Fetch restarts at RESET_PC.
- fetch_pc at 32'hFFFF_FFFC → next request addr 32'h0, pc_plus4_F=32'h0 for that entry. With FETCH_QUEUE_BYPASS_EN, the empty-queue response appears on valid_F the same cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch buffer that sits between instruction memory and the
// IF/ID pipeline register. It streams sequential fetch requests to a
// variable-latency imem, queues the returned words together with their PC+4,
// and hands them to decode in program order. A decode stall is absorbed by
// the queue, so nothing is fetched twice. A taken branch or jump flushes the
// queue, discards every response that is still in flight, and restarts
// fetching at the redirect target.
//
// Parameters:
//   DEPTH     number of queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk             sole clock, rising edge
//   reset           synchronous, active-high
//   imem_req_valid  fetch request valid
//   imem_req_ready  imem accepts the request this cycle
//   imem_addr       word-aligned fetch address
//   imem_rsp_valid  response word valid (in request order)
//   imem_rsp_data   returned instruction word
//   redirect        taken branch/jump resolved in decode
//   redirect_pc     redirect target, bits [1:0] forced to zero
//   take            decode consumes the head entry
//   valid_F         head entry valid
//   inst_F          head instruction (0 when !valid_F)
//   pc_plus4_F      head PC+4 (0 when !valid_F)
//   empty           no buffered entries
//   full            every entry occupied
//
// Build option:
//   FETCH_QUEUE_BYPASS_EN  when defined, a response that lands on an empty
//                          queue is shown on the head outputs in the same
//                          cycle. When undefined, the head outputs come
//                          straight from registers.
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        take,
    output logic        valid_F,
    output logic [31:0] inst_F,
    output logic [31:0] pc_plus4_F,
    output logic        empty,
    output logic        full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [SW-1:0] DEPTH_SUM = SW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    typedef enum logic {
        FETCH,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc4_mem_q  [DEPTH];

    logic          req_fire;
    logic          rsp_take;
    logic          rsp_push;
    logic          bypass_hit;
    logic          pop;
    logic          store;
    logic [PW-1:0] tag_slot;
    logic [SW-1:0] inflight;
    logic [31:0]   head_inst;
    logic [31:0]   head_pc4;
    logic          unused_pc_bits;

    // The low two redirect bits are never used: targets are word aligned.
    assign unused_pc_bits = ^redirect_pc[1:0];

    // Buffered plus in-flight words must never exceed the storage, so every
    // issued request is guaranteed a slot when its response comes back.
    assign inflight = {1'b0, count_q} + {1'b0, outst_q};

    assign imem_req_valid = !reset && (state_q == FETCH) && !redirect
                            && (inflight < DEPTH_SUM);
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response only retires a request this instance actually issued; a
    // response with nothing outstanding belongs to a request abandoned by
    // reset and is ignored.
    assign rsp_take = !reset && imem_rsp_valid && (outst_q != '0);
    assign rsp_push = rsp_take && !redirect && (state_q == FETCH)
                      && (drop_q == '0);

    // In-flight requests occupy wr_ptr .. wr_ptr+outstanding-1, so the next
    // request's PC+4 goes to the slot just beyond them.
    assign tag_slot = wr_ptr_q + outst_q[PW-1:0];

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_hit = rsp_push && (count_q == '0);
`else
    assign bypass_hit = 1'b0;
`endif

    // With an empty queue rd_ptr equals wr_ptr, so the PC+4 tagged for the
    // arriving word is already at the read pointer.
    assign head_inst = bypass_hit ? imem_rsp_data : inst_mem_q[rd_ptr_q];
    assign head_pc4  = pc4_mem_q[rd_ptr_q];

    assign valid_F    = (count_q != '0) || bypass_hit;
    assign inst_F     = valid_F ? head_inst : 32'h0;
    assign pc_plus4_F = valid_F ? head_pc4  : 32'h0;
    assign empty      = (count_q == '0);
    assign full       = (count_q == DEPTH_CNT);

    assign pop = take && valid_F && !redirect;

    // A bypassed word consumed in the same cycle never needs storing, but
    // both pointers still advance so later PC tags stay aligned.
    assign store = rsp_push && !(bypass_hit && pop);

    // Next-state logic: a redirect overrides everything; otherwise issue,
    // retire, push and pop update the queue bookkeeping independently.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;

        if (redirect) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            outst_d    = outst_q - (rsp_take ? CNT_ONE : '0);
            drop_d     = outst_d;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            state_d    = (drop_d != '0) ? DRAIN : FETCH;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            outst_d = outst_q + (req_fire ? CNT_ONE : '0)
                              - (rsp_take ? CNT_ONE : '0);

            if (rsp_take && (drop_q != '0)) begin
                drop_d = drop_q - CNT_ONE;
                if (drop_d == '0) begin
                    state_d = FETCH;
                end
            end

            if (rsp_push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end

            case ({rsp_push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    // Queue storage: PC+4 is tagged when the request is issued, the word is
    // written when its response is pushed. Contents are only observed
    // through valid entries, so no reset is needed.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc4_mem_q[tag_slot] <= imem_addr + 32'd4;
        end
        if (store) begin
            inst_mem_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue in its default build (bypass disabled).
// A small imem model answers each accepted request with its own address as
// the instruction word after a programmable latency, in request order. It
// keeps answering requests that reset abandoned so stale responses reach the
// design. Each step of the single initial block drives inputs at the falling
// edge and checks outputs 1 time unit later.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        take;
    logic        valid_F;
    logic [31:0] inst_F;
    logic [31:0] pc_plus4_F;
    logic        empty;
    logic        full;

    int          checks  = 0;
    int          errors  = 0;
    int          cycle   = 0;
    int          latency = 1;
    logic [31:0] pendAddr [$];
    int          pendDue  [$];

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .take           (take),
        .valid_F        (valid_F),
        .inst_F         (inst_F),
        .pc_plus4_F     (pc_plus4_F),
        .empty          (empty),
        .full           (full)
    );

    // One comparison: counts it, and reports tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock: record the handshakes seen before the edge, update
    // the imem model, then drive this cycle's response at the falling edge.
    task automatic applyStimulus();
        logic        fire;
        logic [31:0] addr;
        logic        rspNow;
        fire   = imem_req_valid && imem_req_ready;
        addr   = imem_addr;
        rspNow = imem_rsp_valid;
        @(posedge clk);
        if (rspNow) begin
            void'(pendAddr.pop_front());
            void'(pendDue.pop_front());
        end
        if (fire) begin
            pendAddr.push_back(addr);
            pendDue.push_back(cycle + latency);
        end
        cycle++;
        @(negedge clk);
        if (pendAddr.size() != 0 && pendDue[0] <= cycle) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pendAddr[0];
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        if (imem_rsp_valid) begin
            checkOutput("rsp_while_full", 32'(full), 32'd0);
        end
    endtask

    // All outputs at their reset values.
    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"},    32'(valid_F),        32'd0);
        checkOutput({tag, "_inst"},     inst_F,              32'd0);
        checkOutput({tag, "_pc4"},      pc_plus4_F,          32'd0);
        checkOutput({tag, "_empty"},    32'(empty),          32'd1);
        checkOutput({tag, "_full"},     32'(full),           32'd0);
        checkOutput({tag, "_reqvalid"}, 32'(imem_req_valid), 32'd0);
    endtask

    // Hold reset until the imem model has nothing pending, check the reset
    // state, then release reset; the caller continues in cycle 0.
    task automatic doReset(input logic takeAfter);
        reset    = 1'b1;
        take     = 1'b0;
        redirect = 1'b0;
        for (int n = 0; n < 3; n++) applyStimulus();
        for (int n = 0; n < 20 && pendAddr.size() != 0; n++) applyStimulus();
        if (pendAddr.size() != 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL reset_drain: observed=%0d pending expected=0", pendAddr.size());
        end
        #1;
        checkIdle("reset");
        reset = 1'b0;
        take  = takeAfter;
        cycle = 0;
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        take           = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;

        // Streaming with a 1-cycle imem and decode always taking.
        $display("[TB] streaming, latency 1");
        latency = 1;
        doReset(1'b1);
        checkOutput("t1_reqvalid_c0", 32'(imem_req_valid), 32'd1);
        checkOutput("t1_addr_c0",     imem_addr,           32'h0);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus();
            #1;
            checkOutput("t1_addr", imem_addr, 32'(4 * k));
            if (k == 1) begin
                checkOutput("t1_valid_c1", 32'(valid_F), 32'd0);
            end else begin
                checkOutput("t1_valid", 32'(valid_F), 32'd1);
                checkOutput("t1_inst",  inst_F,       32'(4 * (k - 2)));
                checkOutput("t1_pc4",   pc_plus4_F,   32'(4 * (k - 1)));
            end
        end

        // Decode stalled for 10 cycles, then resumes.
        $display("[TB] stall then resume");
        doReset(1'b0);
        for (int c = 1; c <= 10; c++) begin
            applyStimulus();
            #1;
            if (c == 3) checkOutput("t2_full_c3", 32'(full), 32'd0);
        end
        checkOutput("t2_full",     32'(full),           32'd1);
        checkOutput("t2_reqvalid", 32'(imem_req_valid), 32'd0);
        checkOutput("t2_empty",    32'(empty),          32'd0);
        checkOutput("t2_addr",     imem_addr,           32'h10);
        checkOutput("t2_inst_c10", inst_F,              32'h0);
        take = 1'b1;
        for (int c = 11; c <= 16; c++) begin
            applyStimulus();
            #1;
            checkOutput("t2_valid", 32'(valid_F), 32'd1);
            checkOutput("t2_inst",  inst_F,       32'(4 * (c - 10)));
            checkOutput("t2_pc4",   pc_plus4_F,   32'(4 * (c - 9)));
        end

        // Redirect with three requests in flight, 3-cycle imem.
        $display("[TB] redirect while draining");
        latency = 3;
        doReset(1'b0);
        for (int c = 1; c <= 3; c++) applyStimulus();
        #1;
        checkOutput("t3_reqvalid_pre", 32'(imem_req_valid), 32'd1);
        checkOutput("t3_addr_pre",     imem_addr,           32'hC);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        #1;
        checkOutput("t3_reqvalid_redir", 32'(imem_req_valid), 32'd0);
        applyStimulus();
        redirect = 1'b0;
        #1;
        checkOutput("t3_reqvalid_c4", 32'(imem_req_valid), 32'd0);
        checkOutput("t3_empty_c4",    32'(empty),          32'd1);
        checkOutput("t3_valid_c4",    32'(valid_F),        32'd0);
        applyStimulus();
        #1;
        checkOutput("t3_reqvalid_c5", 32'(imem_req_valid), 32'd0);
        applyStimulus();
        #1;
        checkOutput("t3_reqvalid_c6", 32'(imem_req_valid), 32'd1);
        checkOutput("t3_addr_c6",     imem_addr,           32'h100);
        for (int c = 7; c <= 9; c++) applyStimulus();
        #1;
        checkOutput("t3_valid_c9", 32'(valid_F), 32'd0);
        applyStimulus();
        #1;
        checkOutput("t3_valid_c10", 32'(valid_F), 32'd1);
        checkOutput("t3_inst_c10",  inst_F,       32'h100);
        checkOutput("t3_pc4_c10",   pc_plus4_F,   32'h104);

        // Redirect coinciding with a response and a take.
        $display("[TB] redirect with response and take");
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        take        = 1'b1;
        applyStimulus();
        redirect = 1'b0;
        take     = 1'b0;
        #1;
        checkOutput("t4_empty_c11",    32'(empty),          32'd1);
        checkOutput("t4_valid_c11",    32'(valid_F),        32'd0);
        checkOutput("t4_inst_c11",     inst_F,              32'h0);
        checkOutput("t4_reqvalid_c11", 32'(imem_req_valid), 32'd0);
        applyStimulus();
        #1;
        checkOutput("t4_reqvalid_c12", 32'(imem_req_valid), 32'd0);
        applyStimulus();
        #1;
        checkOutput("t4_reqvalid_c13", 32'(imem_req_valid), 32'd1);
        checkOutput("t4_addr_c13",     imem_addr,           32'h200);
        for (int c = 14; c <= 17; c++) applyStimulus();
        #1;
        checkOutput("t4_valid_c17", 32'(valid_F), 32'd1);
        checkOutput("t4_inst_c17",  inst_F,       32'h200);
        checkOutput("t4_pc4_c17",   pc_plus4_F,   32'h204);

        // Reset with two requests outstanding; their responses arrive late.
        $display("[TB] reset with requests in flight");
        latency = 3;
        doReset(1'b0);
        applyStimulus();
        applyStimulus();
        #1;
        checkOutput("t5_addr_c2", imem_addr, 32'h8);
        reset = 1'b1;
        #1;
        checkOutput("t5_reqvalid_rst", 32'(imem_req_valid), 32'd0);
        applyStimulus();
        #1;
        checkIdle("t5_rst");
        applyStimulus();
        reset = 1'b0;
        #1;
        checkOutput("t5_reqvalid_c4", 32'(imem_req_valid), 32'd1);
        checkOutput("t5_addr_c4",     imem_addr,           32'h0);
        applyStimulus();
        #1;
        checkOutput("t5_valid_c5", 32'(valid_F), 32'd0);
        checkOutput("t5_empty_c5", 32'(empty),   32'd1);
        checkOutput("t5_addr_c5",  imem_addr,    32'h4);
        for (int c = 6; c <= 8; c++) applyStimulus();
        #1;
        checkOutput("t5_valid_c8", 32'(valid_F), 32'd1);
        checkOutput("t5_inst_c8",  inst_F,       32'h0);
        checkOutput("t5_pc4_c8",   pc_plus4_F,   32'h4);

        // Fetch address wrap at the top of the address space.
        $display("[TB] address wrap");
        latency = 1;
        doReset(1'b0);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        checkOutput("t6_reqvalid_redir", 32'(imem_req_valid), 32'd0);
        applyStimulus();
        redirect = 1'b0;
        take     = 1'b1;
        #1;
        checkOutput("t6_reqvalid_c1", 32'(imem_req_valid), 32'd1);
        checkOutput("t6_addr_c1",     imem_addr,           32'hFFFF_FFFC);
        applyStimulus();
        #1;
        checkOutput("t6_addr_c2",  imem_addr,    32'h0);
        checkOutput("t6_valid_c2", 32'(valid_F), 32'd0);
        applyStimulus();
        #1;
        checkOutput("t6_valid_c3", 32'(valid_F), 32'd1);
        checkOutput("t6_inst_c3",  inst_F,       32'hFFFF_FFFC);
        checkOutput("t6_pc4_c3",   pc_plus4_F,   32'h0);
        applyStimulus();
        #1;
        checkOutput("t6_inst_c4", inst_F,     32'h0);
        checkOutput("t6_pc4_c4",  pc_plus4_F, 32'h4);
        applyStimulus();
        #1;
        checkOutput("t6_inst_c5", inst_F,     32'h4);
        checkOutput("t6_pc4_c5",  pc_plus4_F, 32'h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a run that never reaches the end of the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
